imem_fetch_unit: RTL and testbench
==================================

// Module: imem_fetch_unit
// PURPOSE
// - Parametrised instruction memory for the RV32I core: fetch port with valid/ready handshake, registered 1-cycle read.
// - Byte-strobed load port lets the testbench or bootloader write programs.
// - Hardware clear sequence after reset; alignment and range fault reporting.
// - Sits between the PC/fetch stage and the decode stage.
// PARAMETERS
// - XLEN        32            instruction/data word width (multiple of 8)
// - DEPTH       256           number of words (power of 2, >=4)
// - BASE_ADDR   32'h0000_0000 byte address of word 0 (DEPTH*XLEN/8 aligned)
// - CLEAR_WORD  32'h0000_0013 value written to every word at init (addi x0,x0,0 = NOP)
// PORTS
// - clk              in   1        rising-edge clock
// - resetn           in   1        asynchronous active-low reset
// - fetch_req_valid  in   1        fetch request present
// - fetch_req_ready  out  1        fetch request accepted this cycle when valid&ready
// - fetch_req_addr   in   32       byte address of instruction
// - fetch_rsp_valid  out  1        response held in output register
// - fetch_rsp_ready  in   1        consumer takes response when valid&ready
// - fetch_rsp_instr  out  XLEN     instruction word (0 when fault != OK)
// - fetch_rsp_fault  out  2        00 OK, 01 MISALIGNED, 10 OUT_OF_RANGE
// - load_valid       in   1        load write present
// - load_ready       out  1        = init_done
// - load_addr        in   32       byte address of word to write
// - load_data        in   XLEN     write data
// - load_wstrb       in   XLEN/8   byte enables
// - load_err         out  1        sticky: a load was dropped (misaligned/out of range)
// - init_done        out  1        clear sequence finished
// BEHAVIOUR
// - Reset (async, resetn=0):
//   - FSM=CLEAR, clr_cnt=0, fetch_rsp_valid=0, fetch_rsp_instr=0, fetch_rsp_fault=0, load_err=0, init_done=0.
//   - Memory contents are not reset directly.
// - CLEAR state:
//   - One word per cycle: mem[clr_cnt]<=CLEAR_WORD, clr_cnt++.
//   - After word DEPTH-1 -> READY. CLEAR lasts exactly DEPTH cycles.
//   - fetch_req_ready=0, load_ready=0 throughout.
// - READY state: init_done=1. Only reset leaves READY.
// - Address decode: off = addr - BASE_ADDR.
//   - MISALIGNED if addr[1:0]!=0 (checked first).
//   - OUT_OF_RANGE if addr<BASE_ADDR or off>=DEPTH*4.
//   - Otherwise index = off[log2(DEPTH)+1:2].
// - Fetch handshake:
//   - fetch_req_ready = READY && (!fetch_rsp_valid || fetch_rsp_ready), combinational, no dependence on fetch_req_valid.
//   - On accept, the next edge loads the response register: fetch_rsp_valid=1, instr=mem[index] (or 0), fault code. Latency 1 cycle.
//   - Back-to-back accepts give 1 response/cycle while fetch_rsp_ready=1.
//   - Response held stable while valid&!ready.
//   - Response consumed and no new accept -> fetch_rsp_valid=0 next cycle.
// - Load port:
//   - On load_valid&load_ready with a legal address, write bytes i where load_wstrb[i]=1.
//   - Illegal address: no write, load_err<=1 (sticky until reset).
// - Simultaneous fetch and load:
//   - Both proceed; the RAM has 1 read port and 1 write port.
//   - Same word: the fetch returns OLD data (read-first).
// - Reset mid-operation: in-flight response discarded, load aborted, CLEAR restarts from word 0.
// - Widths: clr_cnt is log2(DEPTH) bits. Offset compare uses 33-bit arithmetic so no wrap at 32'hFFFF_FFFC.
// STRUCTURE
// - imem_pkg holds:
//   - typedef enum logic[1:0] {FAULT_OK, FAULT_MISALIGNED, FAULT_OOR} imem_fault_e
//   - typedef enum logic {ST_CLEAR, ST_READY} imem_state_e
//   - localparam NOP_WORD = 32'h0000_0013
// - Sub-module imem_ram: 1R1W synchronous RAM, byte-enable write, read-first. Parameters XLEN, DEPTH.
// - Top level holds the FSM, address decode, response register and load_err.
// TESTING
// - Reset, then hold fetch_req_valid=1 addr 0 -> ready=0 for 256 cycles; init_done rises cycle 256; first rsp instr=32'h13, fault=0.
// - Load 0x00500093 @0x4, then fetch 0x4 -> next cycle rsp_valid=1, instr=0x00500093; wstrb=4'b0001 data 0xFF @0x4 -> 0x005000FF.
// - fetch 0x6 -> fault=01, instr=0; fetch 0x400 (DEPTH=256) -> fault=10; load @0x402 -> no write, load_err=1 and stays 1.
// - Stream addrs 0,4,8 with rsp_ready toggling 1,0,1 -> responses in order, no drops/dups, rsp stable while stalled, req_ready=0 while stalled.
// - Same cycle: load 0xDEADBEEF @0x8 and fetch 0x8 -> rsp returns old word; next fetch 0x8 -> 0xDEADBEEF.
// - Assert resetn=0 with rsp_valid=1 pending -> rsp_valid=0 immediately; full CLEAR rerun, all words read back 0x13.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch unit.
package imem_pkg;

   typedef enum logic [1:0] {
      FAULT_OK         = 2'b00,
      FAULT_MISALIGNED = 2'b01,
      FAULT_OOR        = 2'b10
   } imem_fault_e;

   typedef enum logic {ST_CLEAR, ST_READY} imem_state_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_ram.sv
// 1R1W synchronous RAM with byte-enable write and read-first behaviour.
module imem_ram #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 256,
   localparam int unsigned IdxW = $clog2(DEPTH),
   localparam int unsigned NB   = XLEN / 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            re,
   input  logic [IdxW-1:0] raddr,
   output logic [XLEN-1:0] rdata,
   input  logic            we,
   input  logic [IdxW-1:0] waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [NB-1:0]   be
);

   logic [XLEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read data register only updates on a read, so a stalled response stays stable.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with valid/ready fetch port, byte-strobed load port and
// a post-reset clear sequence that fills every word with CLEAR_WORD.
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     DEPTH      = 256,
   parameter logic [31:0]     BASE_ADDR  = 32'h0000_0000,
   parameter logic [XLEN-1:0] CLEAR_WORD = XLEN'(NOP_WORD)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              fetch_req_valid,
   output logic              fetch_req_ready,
   input  logic [31:0]       fetch_req_addr,
   output logic              fetch_rsp_valid,
   input  logic              fetch_rsp_ready,
   output logic [XLEN-1:0]   fetch_rsp_instr,
   output logic [1:0]        fetch_rsp_fault,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [31:0]       load_addr,
   input  logic [XLEN-1:0]   load_data,
   input  logic [XLEN/8-1:0] load_wstrb,
   output logic              load_err,
   output logic              init_done
);

   localparam int unsigned NB   = XLEN / 8;
   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned OffW = $clog2(NB);
   localparam logic [32:0] Span = 33'(DEPTH * NB);

   // 33-bit offset so addresses near 32'hFFFF_FFFC cannot wrap into range.
   function automatic imem_fault_e decode_fault(input logic [31:0] addr);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, BASE_ADDR};
      if (addr[OffW-1:0] != '0) return FAULT_MISALIGNED;
      if (off[32] || off >= Span) return FAULT_OOR;
      return FAULT_OK;
   endfunction

   imem_state_e     state_q, state_d;
   logic [IdxW-1:0] clr_cnt_q, clr_cnt_d;
   logic            rsp_valid_q;
   imem_fault_e     rsp_fault_q;
   logic            load_err_q;

   imem_fault_e     fetch_fault, load_fault;
   logic [IdxW-1:0] fetch_idx, load_idx;
   logic            fetch_accept, load_fire;
   logic            ram_re, ram_we;
   logic [IdxW-1:0] ram_waddr;
   logic [XLEN-1:0] ram_wdata, ram_rdata;
   logic [NB-1:0]   ram_be;

   assign fetch_fault = decode_fault(fetch_req_addr);
   assign load_fault  = decode_fault(load_addr);
   // BASE_ADDR is span-aligned, so the offset index equals these address bits.
   assign fetch_idx   = fetch_req_addr[IdxW+OffW-1:OffW];
   assign load_idx    = load_addr[IdxW+OffW-1:OffW];

   assign fetch_req_ready = init_done && (!rsp_valid_q || fetch_rsp_ready);
   assign load_ready      = init_done;
   assign fetch_accept    = fetch_req_valid && fetch_req_ready;
   assign load_fire       = load_valid && load_ready;
   assign ram_re          = fetch_accept && (fetch_fault == FAULT_OK);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      init_done = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = load_idx;
      ram_wdata = load_data;
      ram_be    = load_wstrb;
      unique case (state_q)
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = CLEAR_WORD;
            ram_be    = '1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IdxW'(DEPTH - 1)) state_d = ST_READY;
         end
         ST_READY: begin
            init_done = 1'b1;
            ram_we    = load_fire && (load_fault == FAULT_OK);
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= FAULT_OK;
      end else if (fetch_accept) begin
         rsp_valid_q <= 1'b1;
         rsp_fault_q <= fetch_fault;
      end else if (fetch_rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         load_err_q <= 1'b0;
      end else if (load_fire && (load_fault != FAULT_OK)) begin
         load_err_q <= 1'b1;
      end
   end

   assign fetch_rsp_valid = rsp_valid_q;
   assign fetch_rsp_fault = rsp_fault_q;
   assign fetch_rsp_instr = (rsp_fault_q == FAULT_OK) ? ram_rdata : '0;
   assign load_err        = load_err_q;

   imem_ram #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .resetn (resetn),
      .re     (ram_re),
      .raddr  (fetch_idx),
      .rdata  (ram_rdata),
      .we     (ram_we),
      .waddr  (ram_waddr),
      .wdata  (ram_wdata),
      .be     (ram_be)
   );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: clear sequence, loads, faults, stalls,
// read-first collision and reset mid-operation.
module tb_imem_fetch_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        fetch_req_valid;
   logic        fetch_req_ready;
   logic [31:0] fetch_req_addr;
   logic        fetch_rsp_valid;
   logic        fetch_rsp_ready;
   logic [31:0] fetch_rsp_instr;
   logic [1:0]  fetch_rsp_fault;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic [3:0]  load_wstrb;
   logic        load_err;
   logic        init_done;

   int vec  = 0;
   int miss = 0;

   always #5 clk = ~clk;

   imem_fetch_unit dut (
      .clk             (clk),
      .resetn          (resetn),
      .fetch_req_valid (fetch_req_valid),
      .fetch_req_ready (fetch_req_ready),
      .fetch_req_addr  (fetch_req_addr),
      .fetch_rsp_valid (fetch_rsp_valid),
      .fetch_rsp_ready (fetch_rsp_ready),
      .fetch_rsp_instr (fetch_rsp_instr),
      .fetch_rsp_fault (fetch_rsp_fault),
      .load_valid      (load_valid),
      .load_ready      (load_ready),
      .load_addr       (load_addr),
      .load_data       (load_data),
      .load_wstrb      (load_wstrb),
      .load_err        (load_err),
      .init_done       (init_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp)
      else begin
         miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] a);
      fetch_req_valid = 1'b1;
      fetch_req_addr  = a;
      tick();
      fetch_req_valid = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      load_wstrb = s;
      tick();
      load_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int bad;
      resetn          = 1'b0;
      fetch_req_valid = 1'b0;
      fetch_req_addr  = '0;
      fetch_rsp_ready = 1'b1;
      load_valid      = 1'b0;
      load_addr       = '0;
      load_data       = '0;
      load_wstrb      = '0;
      #1;
      chk("rst_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
      chk("rst_instr", fetch_rsp_instr, 32'h0);
      chk("rst_fault", 32'(fetch_rsp_fault), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      tick();
      tick();

      // Clear sequence with a fetch request held the whole time
      resetn          = 1'b1;
      fetch_req_valid = 1'b1;
      fetch_req_addr  = 32'h0;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         #1;
         if (fetch_req_ready !== 1'b0 || load_ready !== 1'b0 || init_done !== 1'b0) bad++;
         tick();
      end
      chk("clear_busy_cycles", 32'(bad), 32'd0);
      #1;
      chk("init_done_rise", 32'(init_done), 32'd1);
      chk("req_ready_after_clear", 32'(fetch_req_ready), 32'd1);
      chk("load_ready_after_clear", 32'(load_ready), 32'd1);
      tick();
      fetch_req_valid = 1'b0;
      chk("first_rsp_valid", 32'(fetch_rsp_valid), 32'd1);
      chk("first_rsp_instr", fetch_rsp_instr, 32'h0000_0013);
      chk("first_rsp_fault", 32'(fetch_rsp_fault), 32'd0);
      tick();
      chk("rsp_drained", 32'(fetch_rsp_valid), 32'd0);

      // Full-word load then a byte-strobed overwrite
      do_load(32'h4, 32'h0050_0093, 4'hF);
      do_fetch(32'h4);
      chk("load_fetch_valid", 32'(fetch_rsp_valid), 32'd1);
      chk("load_fetch_instr", fetch_rsp_instr, 32'h0050_0093);
      do_load(32'h4, 32'h0000_00FF, 4'b0001);
      do_fetch(32'h4);
      chk("strobe_instr", fetch_rsp_instr, 32'h0050_00FF);

      // Faults and range boundaries
      do_fetch(32'h6);
      chk("misaligned_fault", 32'(fetch_rsp_fault), 32'd1);
      chk("misaligned_instr", fetch_rsp_instr, 32'h0);
      do_fetch(32'h400);
      chk("oor_fault", 32'(fetch_rsp_fault), 32'd2);
      chk("oor_instr", fetch_rsp_instr, 32'h0);
      do_fetch(32'h3FC);
      chk("last_word_fault", 32'(fetch_rsp_fault), 32'd0);
      chk("last_word_instr", fetch_rsp_instr, 32'h0000_0013);
      do_fetch(32'hFFFF_FFFC);
      chk("top_addr_fault", 32'(fetch_rsp_fault), 32'd2);
      chk("load_err_clean", 32'(load_err), 32'd0);
      do_load(32'h402, 32'h1234_5678, 4'hF);
      chk("load_err_set", 32'(load_err), 32'd1);
      do_fetch(32'h0);
      chk("bad_load_no_write", fetch_rsp_instr, 32'h0000_0013);
      chk("load_err_sticky", 32'(load_err), 32'd1);

      // Streaming with a one-cycle consumer stall
      do_load(32'h0, 32'hA0A0_A0A0, 4'hF);
      do_load(32'h8, 32'h1111_1111, 4'hF);
      fetch_req_valid = 1'b1;
      fetch_req_addr  = 32'h0;
      tick();
      chk("stream0_instr", fetch_rsp_instr, 32'hA0A0_A0A0);
      fetch_req_addr  = 32'h4;
      fetch_rsp_ready = 1'b0;
      #1;
      chk("stall_req_ready", 32'(fetch_req_ready), 32'd0);
      tick();
      chk("stall_rsp_valid", 32'(fetch_rsp_valid), 32'd1);
      chk("stall_rsp_stable", fetch_rsp_instr, 32'hA0A0_A0A0);
      fetch_rsp_ready = 1'b1;
      #1;
      chk("unstall_req_ready", 32'(fetch_req_ready), 32'd1);
      tick();
      chk("stream1_instr", fetch_rsp_instr, 32'h0050_00FF);
      fetch_req_addr = 32'h8;
      tick();
      chk("stream2_instr", fetch_rsp_instr, 32'h1111_1111);
      fetch_req_valid = 1'b0;
      tick();
      chk("stream_drained", 32'(fetch_rsp_valid), 32'd0);

      // Same-word load and fetch in one cycle: read-first
      load_valid      = 1'b1;
      load_addr       = 32'h8;
      load_data       = 32'hDEAD_BEEF;
      load_wstrb      = 4'hF;
      fetch_req_valid = 1'b1;
      fetch_req_addr  = 32'h8;
      tick();
      load_valid      = 1'b0;
      fetch_req_valid = 1'b0;
      chk("collide_old_data", fetch_rsp_instr, 32'h1111_1111);
      do_fetch(32'h8);
      chk("collide_new_data", fetch_rsp_instr, 32'hDEAD_BEEF);

      // Reset with a response pending
      fetch_rsp_ready = 1'b0;
      tick();
      chk("pending_before_reset", 32'(fetch_rsp_valid), 32'd1);
      resetn = 1'b0;
      #1;
      chk("reset_kills_rsp", 32'(fetch_rsp_valid), 32'd0);
      chk("reset_instr", fetch_rsp_instr, 32'h0);
      chk("reset_load_err", 32'(load_err), 32'd0);
      chk("reset_init_done", 32'(init_done), 32'd0);
      tick();
      tick();
      resetn          = 1'b1;
      fetch_rsp_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         #1;
         if (init_done !== 1'b0 || fetch_req_ready !== 1'b0) bad++;
         tick();
      end
      chk("reclear_busy_cycles", 32'(bad), 32'd0);
      chk("reclear_init_done", 32'(init_done), 32'd1);

      // Every word reads back as the clear value
      bad = 0;
      fetch_req_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         fetch_req_addr = 32'(i * 4);
         tick();
         if (fetch_rsp_valid !== 1'b1 || fetch_rsp_instr !== 32'h0000_0013 ||
             fetch_rsp_fault !== 2'd0) bad++;
      end
      fetch_req_valid = 1'b0;
      chk("readback_all_nop", 32'(bad), 32'd0);
      tick();
      chk("final_drained", 32'(fetch_rsp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
